// File: rtl/spi_fram_ctrl_if.sv
// spi_fram_ctrl_if: CPU-side memory bus between a core and spi_fram_ctrl.
//
// Signals:
//   req_read, req_write  single-cycle or held request strobes (core -> ctrl)
//   req_addr             byte address, low two bits ignored (core -> ctrl)
//   req_wdata            write word (core -> ctrl)
//   rdata, rdata_valid   read word and its one-cycle update pulse (ctrl -> core)
//   mem_read, mem_write  transaction-type status (ctrl -> core)
//   mem_busy             controller is not in IDLE (ctrl -> core)
//
// Modports: master = core side, slave = controller side.
interface spi_fram_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              mem_read;
  logic              mem_write;
  logic              mem_busy;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  rdata, rdata_valid, mem_read, mem_write, mem_busy
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output rdata, rdata_valid, mem_read, mem_write, mem_busy
  );
endinterface

// File: rtl/spi_fram_ctrl.sv
// spi_fram_ctrl: SPI mode-0 master turning single-word CPU requests into
// MB85RS64V-style FRAM frames (WREN + WRITE, READ), 32-bit little-endian words.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   bus        spi_fram_ctrl_if.slave (requests in, rdata/status out)
//   spi_cs     chip select, active-low
//   spi_sck    serial clock, idles low, period 2*CLK_DIV clk cycles
//   spi_mosi   master out, changes on SCK falling edge
//   spi_miso   master in, sampled on SCK rising edge
//
// Build option: define FRAM_FASTREAD_EN to issue reads as FSTRD (0x0B) with
// one dummy byte after the address; writes are unaffected.
module spi_fram_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_fram_ctrl_if.slave        bus,
  output logic                  spi_cs,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef FRAM_FASTREAD_EN
  localparam logic [7:0] OP_READ  = 8'h0B;
`else
  localparam logic [7:0] OP_READ  = 8'h03;
`endif

  typedef enum logic [2:0] {IDLE, WREN, GAP, CMD, ADDR, DATA, FINISH} state_t;

  state_t            state;
  state_t            nxt_state;
  logic [7:0]        div_cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [2:0]        nxt_byte_cnt;
  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        tx;
  logic [7:0]        rx_byte;
  logic [31:0]       rx;
  logic [7:0]        nxt_byte;
  logic [15:0]       addr16;
  logic              tick;

  // Word-aligned 16-bit address field as sent on the wire.
  assign addr16 = 16'(addr_q) & 16'hFFFC;
  assign tick   = (div_cnt == 8'(CLK_DIV - 1));

  // Next byte/state chosen when the current byte finishes on an SCK fall.
  // A zero next byte also parks MOSI low while CS rises.
  always_comb begin
    nxt_state    = state;
    nxt_byte     = 8'h00;
    nxt_byte_cnt = 3'd0;
    case (state)
      WREN: nxt_state = GAP;
      CMD: begin
        nxt_state = ADDR;
        nxt_byte  = addr16[15:8];
      end
      ADDR: begin
        if (byte_cnt == 3'd0) begin
          nxt_byte     = addr16[7:0];
          nxt_byte_cnt = 3'd1;
        end
`ifdef FRAM_FASTREAD_EN
        else if (byte_cnt == 3'd1 && !is_write) begin
          // Dummy byte; stays in ADDR so MISO is never captured here.
          nxt_byte     = 8'h00;
          nxt_byte_cnt = 3'd2;
        end
`endif
        else begin
          nxt_state = DATA;
          nxt_byte  = wdata_q[7:0];
        end
      end
      DATA: begin
        if (byte_cnt == 3'd3) begin
          nxt_state = FINISH;
        end else begin
          nxt_byte     = wdata_q[15:8];
          nxt_byte_cnt = byte_cnt + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      is_write        <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      tx              <= '0;
      rx_byte         <= '0;
      rx              <= '0;
      spi_cs          <= 1'b1;
      spi_sck         <= 1'b0;
      spi_mosi        <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_busy    <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      bus.rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (bus.req_write || bus.req_read) begin
            // Write has priority; read data path carries zeros on MOSI.
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_write ? bus.req_wdata : 32'h0;
            is_write      <= bus.req_write;
            bus.mem_busy  <= 1'b1;
            bus.mem_write <= bus.req_write;
            bus.mem_read  <= !bus.req_write;
            spi_cs        <= 1'b0;
            if (bus.req_write) begin
              state    <= WREN;
              tx       <= OP_WREN;
              spi_mosi <= OP_WREN[7];
            end else begin
              state    <= CMD;
              tx       <= OP_READ;
              spi_mosi <= OP_READ[7];
            end
          end
        end

        // Three divider ticks: CS high after the first, leave after the third,
        // giving CLK_DIV of CS-low hold then 2*CLK_DIV of CS high.
        GAP, FINISH: begin
          if (tick) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd0) begin
              spi_cs <= 1'b1;
            end else if (bit_cnt == 3'd2) begin
              bit_cnt <= '0;
              if (state == GAP) begin
                spi_cs   <= 1'b0;
                state    <= CMD;
                tx       <= OP_WRITE;
                spi_mosi <= OP_WRITE[7];
              end else begin
                state         <= IDLE;
                bus.mem_busy  <= 1'b0;
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        // Shifting states: WREN, CMD, ADDR, DATA.
        default: begin
          if (tick) begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_byte <= {rx_byte[6:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx       <= {tx[6:0], 1'b0};
                spi_mosi <= tx[6];
              end else begin
                bit_cnt  <= '0;
                byte_cnt <= nxt_byte_cnt;
                state    <= nxt_state;
                tx       <= nxt_byte;
                spi_mosi <= nxt_byte[7];
                if (state == DATA) begin
                  // First received byte ends up in rx[7:0] after four pushes.
                  wdata_q <= wdata_q >> 8;
                  rx      <= {rx_byte, rx[31:8]};
                  if (byte_cnt == 3'd3 && !is_write) begin
                    bus.rdata       <= {rx_byte, rx[31:8]};
                    bus.rdata_valid <= 1'b1;
                  end
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
